// File: rtl/series_sum_engine_if.sv
// series_sum_engine_if
//   Start/done handshake bundle for the series-sum compute slave.
//   master : requester (drives Start, Abort, Mode, N_in)
//   slave  : series_sum_engine (drives Busy, Done, Result, Overflow)
//   Parameters WIDTH / ACC_WIDTH must match the attached engine.
interface series_sum_engine_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
);
  logic                 Start;
  logic                 Abort;
  logic                 Mode;
  logic [WIDTH-1:0]     N_in;
  logic                 Busy;
  logic                 Done;
  logic [ACC_WIDTH-1:0] Result;
  logic                 Overflow;

  modport master (
    output Start, Abort, Mode, N_in,
    input  Busy, Done, Result, Overflow
  );

  modport slave (
    input  Start, Abort, Mode, N_in,
    output Busy, Done, Result, Overflow
  );
endinterface

// File: rtl/series_sum_engine.sv
// series_sum_engine
//   Accumulates sum(k) or sum(k*k) for k = 1..N, one term per clock, behind
//   a Start/Done handshake.
//   Ports:
//     Clk    : clock, rising edge
//     Rst_n  : asynchronous active-low reset
//     bus    : series_sum_engine_if.slave
//              Start/Abort/Mode/N_in in; Busy/Done/Result/Overflow out
//   Build option:
//     SERIES_SUM_SATURATE_EN : accumulator clamps at 2^ACC_WIDTH-1 on
//                              overflow instead of wrapping.
module series_sum_engine #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  series_sum_engine_if.slave    bus
);

  // k*k must fit the accumulator without truncation.
  if (ACC_WIDTH < 2 * WIDTH) begin : g_width_check
    $error("series_sum_engine: ACC_WIDTH must be >= 2*WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     c_q, c_d;
  logic [WIDTH-1:0]     n_q, n_d;
  logic                 mode_q, mode_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  logic [2*WIDTH-1:0]   sq;
  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH:0]   add_res;

  // Returns {carry, sum}. With saturation, any carry pins the sum at full
  // scale; since every term is >= 1, a clamped accumulator carries again on
  // each later addition and therefore stays clamped.
  function automatic logic [ACC_WIDTH:0] acc_add(
    input logic [ACC_WIDTH-1:0] a,
    input logic [ACC_WIDTH-1:0] b
  );
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef SERIES_SUM_SATURATE_EN
    if (s[ACC_WIDTH]) s[ACC_WIDTH-1:0] = '1;
`endif
    return s;
  endfunction

  assign sq      = {{WIDTH{1'b0}}, c_q} * {{WIDTH{1'b0}}, c_q};
  assign term    = mode_q ? ACC_WIDTH'(sq) : ACC_WIDTH'(c_q);
  assign add_res = acc_add(acc_q, term);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    n_d     = n_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          n_d     = bus.N_in;
          mode_d  = bus.Mode;
          acc_d   = '0;
          ovf_d   = 1'b0;
          c_d     = WIDTH'(1);
          state_d = (bus.N_in != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // Abort wins over the addition; the partial sum remains visible.
        if (bus.Abort) begin
          state_d = IDLE;
        end else begin
          acc_d = add_res[ACC_WIDTH-1:0];
          ovf_d = ovf_q | add_res[ACC_WIDTH];
          if (c_q == n_q) state_d = DONE;
          else            c_d     = c_q + WIDTH'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      n_q     <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Busy     = (state_q == RUN);
  assign bus.Done     = (state_q == DONE);
  assign bus.Result   = acc_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: doc/series_sum_engine.md
Name: series_sum_engine

Overview:
Parametrised successor to the sum-of-series datapath/controller pair, merged into one block. On a Start pulse it latches N and a mode. It then accumulates the series terms for k = 1..N, one term per clock: either k (arithmetic series) or k*k (sum of squares). It reports the result with a Done pulse, a Busy level and an overflow flag. It sits as a compute slave behind a simple start/done handshake.

Parameters:
- WIDTH, 8: width of N_in and of the internal counter C.
- ACC_WIDTH, 16: width of the accumulator and Result. Must be >= 2*WIDTH; the implementation guards this with an elaboration-time check.

Ports:
- Clk, input, 1: clock, rising edge.
- Rst_n, input, 1: reset, asynchronous, active-low.
- Start, input, 1: request a computation; sampled only in IDLE.
- Abort, input, 1: cancel a computation in progress; honoured in RUN only.
- Mode, input, 1: 0 = sum of k; 1 = sum of k*k. Latched with Start.
- N_in, input, WIDTH: number of terms. Latched with Start.
- Busy, output, 1: high in RUN.
- Done, output, 1: one-cycle pulse when Result is final.
- Result, output, ACC_WIDTH: accumulated sum; held until the next accepted Start.
- Overflow, output, 1: sticky per computation; set if any addition exceeded ACC_WIDTH.

Behaviour:
- Reset is asynchronous, active-low (Rst_n). It forces:
  - state = IDLE
  - C = 0, latched N = 0, latched Mode = 0
  - Result = 0, Overflow = 0, Busy = 0, Done = 0
- Reset mid-RUN discards the computation immediately. No Done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with Start = 1: latch N_in and Mode; clear the accumulator and Overflow; set C = 1.
  - Next state is RUN if N_in != 0, else DONE.
  - On an edge with Start = 0: stay in IDLE.
- RUN, on each edge:
  - term = C when Mode = 0; term = C*C when Mode = 1. C*C is computed at 2*WIDTH bits, then zero-extended to ACC_WIDTH.
  - Accumulator += term.
  - If C == N, go to DONE; otherwise C <= C + 1.
  - Abort = 1 takes priority over the addition. Go to IDLE with the accumulator unchanged, no Done, Busy low next cycle. Result then holds the partial sum.
- DONE: Done = 1 for exactly one cycle; next state is IDLE unconditionally.
- Latency: Start is accepted at edge e0. Additions occur at edges e1..eN. Done is high in the cycle after eN. Busy is high from e0 to eN, i.e. N cycles.
- N = 0: Done is high in the cycle after e0; Result = 0; Busy never asserts.
- Result is the accumulator register itself, updated every RUN edge. It is final and stable from the Done cycle until the next accepted Start.
- Overflow:
  - Computed from the carry out of an (ACC_WIDTH+1)-bit add.
  - Once set, stays set until the next accepted Start.
- Start while in RUN or DONE is ignored, with no queuing. Start and Abort together in IDLE: Start wins, because Abort is ignored outside RUN.
- N_in and Mode changes after e0 have no effect.
- C never wraps: WIDTH bits suffice because C stops at N ≤ 2^WIDTH − 1.

Optional Feature:
- Macro SERIES_SUM_SATURATE_EN.
- When defined: on overflow the accumulator clamps to 2^ACC_WIDTH − 1 and stays clamped for all remaining additions. Overflow is still set.
- When undefined: the accumulator wraps modulo 2^ACC_WIDTH. Overflow is set on the first carry out.
- Latency is identical in both builds.

Test Plan:
- Default params, Mode=0, N_in=10, 1-cycle Start → Busy high 10 cycles; Done pulse 11 cycles after start edge; Result=55; Overflow=0.
- Mode=1, N_in=5 → Result=55, Done after 6 cycles. Then Mode=1, N_in=1 → Result=1. Result holds 55 between runs until the second Start.
- N_in=0 (either mode) → Busy never high; Done in cycle after start edge; Result=0.
- Mode=1, N_in=255, WIDTH=8, ACC_WIDTH=16 → Overflow=1.
  - Macro undefined: Result=54656 (5559680 mod 65536).
  - SERIES_SUM_SATURATE_EN defined: Result=65535.
- Mode=0, N_in=20; Start re-pulsed at cycle 3 → ignored, Result=210. Abort at cycle 5 of a second run → no Done; Busy low next cycle; Result=15 (1+2+3+4+5).
- Rst_n low asynchronously mid-RUN (N_in=50, cycle 7) → all outputs 0 without a clock edge. After release, a fresh Start N_in=4, Mode=0 → Result=10.
